// File: rtl/count_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : count_tick_gen (with helper count_tick_deb)
//  Purpose  : Count-enable generator for the automatic counter. A prescaler
//             divides the board clock into a one-cycle `tick` every DIV
//             cycles while running. A debounced press of KEY_3 toggles
//             between running and paused. The prescaler holds while paused,
//             so a resume continues the partial period.
//  Ports    : PIN_Y2      in  system clock (rising edge)
//             SW17        in  synchronous active-high reset
//             KEY_3       in  raw run/pause button, active-low, asynchronous
//             KEY_2       in  raw step button, active-low (step build only)
//             tick        out one-cycle count enable
//             running     out 1 = auto-counting, 0 = paused
//             key_pressed out one-cycle pulse per debounced KEY_3 press
//  Config   : define COUNT_TICK_STEP_EN to add KEY_2 single-step while paused
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  count_tick_deb: 2-flop synchronizer plus stability-window debouncer.
//  press_o is a registered pulse in the cycle the debounced level falls.
//  Ports: clk_i, rst_i, key_n_i (raw, active-low), press_o
// ----------------------------------------------------------------------------
module count_tick_deb #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] c_dcnt_last = DW'(DEB_CYC - 1);

  logic          s1_q;
  logic          s2_q;
  logic          deb_q;
  logic          press_q;
  logic [DW-1:0] dcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      deb_q   <= 1'b1;
      dcnt_q  <= '0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= key_n_i;
      s2_q    <= s1_q;
      press_q <= 1'b0;
      if (s2_q == deb_q) begin
        // Any return to the accepted level restarts the window.
        dcnt_q <= '0;
      end else if (dcnt_q == c_dcnt_last) begin
        deb_q   <= s2_q;
        dcnt_q  <= '0;
        // Pulse only on the released->pressed (1->0) change.
        press_q <= deb_q;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// ----------------------------------------------------------------------------
//  count_tick_gen: top level
// ----------------------------------------------------------------------------
module count_tick_gen #(
  parameter int DIV     = 50_000_000,
  parameter int DEB_CYC = 1_000_000
) (
  input  logic PIN_Y2,
  input  logic SW17,
  input  logic KEY_3,
`ifdef COUNT_TICK_STEP_EN
  input  logic KEY_2,
`endif
  output logic tick,
  output logic running,
  output logic key_pressed
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] c_pcnt_last = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic          tick_q;
  logic          tick_d;
  logic          running_q;
  logic          running_d;
  logic          w_run_press;
  logic          w_step_press;
  logic          w_wrap;

  count_tick_deb #(.DEB_CYC(DEB_CYC)) u_deb_run (
    .clk_i   (PIN_Y2),
    .rst_i   (SW17),
    .key_n_i (KEY_3),
    .press_o (w_run_press)
  );

`ifdef COUNT_TICK_STEP_EN
  count_tick_deb #(.DEB_CYC(DEB_CYC)) u_deb_step (
    .clk_i   (PIN_Y2),
    .rst_i   (SW17),
    .key_n_i (KEY_2),
    .press_o (w_step_press)
  );
`else
  assign w_step_press = 1'b0;
`endif

  assign w_wrap = (pcnt_q == c_pcnt_last);

  always_comb begin
    pcnt_d    = pcnt_q;
    running_d = running_q ^ w_run_press;
    // Decisions use the pre-edge running flag, so a wrap that coincides
    // with a pause still issues its tick.
    tick_d    = running_q & w_wrap;
    if (running_q) begin
      pcnt_d = w_wrap ? '0 : pcnt_q + 1'b1;
    end
`ifdef COUNT_TICK_STEP_EN
    // Step presses only count while paused; pcnt is left untouched.
    tick_d = tick_d | (~running_q & w_step_press);
`else
    tick_d = tick_d | (w_step_press & 1'b0);
`endif
  end

  always_ff @(posedge PIN_Y2) begin
    if (SW17) begin
      pcnt_q    <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b1;
    end else begin
      pcnt_q    <= pcnt_d;
      tick_q    <= tick_d;
      running_q <= running_d;
    end
  end

  assign tick        = tick_q;
  assign running     = running_q;
  assign key_pressed = w_run_press;

endmodule
`default_nettype wire

// File: tb/tb_count_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_tick_gen
//  Purpose  : Self-checking bench for count_tick_gen (DIV=10, DEB_CYC=4).
//             Reference model: the debounced level changes when the last
//             DEB_CYC synchronized samples all disagree with it; ticks
//             follow from the total number of running cycles modulo DIV.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_tick_gen;

  localparam int DIV = 10;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic k3;
  logic k2;
  logic tick;
  logic running;
  logic kp;

  always #5 clk = ~clk;

  count_tick_gen #(.DIV(DIV), .DEB_CYC(DEB)) dut (
    .PIN_Y2      (clk),
    .SW17        (rst),
    .KEY_3       (k3),
`ifdef COUNT_TICK_STEP_EN
    .KEY_2       (k2),
`endif
    .tick        (tick),
    .running     (running),
    .key_pressed (kp)
  );

  int checks = 0;
  int errors = 0;

  bit     raw3q[$];
  bit     s23q[$];
  bit     raw2q[$];
  bit     s22q[$];
  bit     m_deb3;
  bit     m_deb2;
  bit     m_running;
  bit     m_kp;
  bit     m_sp;
  bit     m_tick;
  longint runcnt;

  // Synchronized level seen by the debouncer: raw input two edges back.
  function automatic bit sync_out(input bit q[$]);
    if (q.size() >= 3) return q[q.size()-3];
    return 1'b1;
  endfunction

  // True when the last DEB synchronized samples all differ from the level.
  function automatic bit win_flip(input bit q[$], input bit lvl);
    if (q.size() < DEB) return 1'b0;
    for (int i = 0; i < DEB; i++)
      if (q[q.size()-1-i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit n_kp;
    bit n_sp;
    bit n_tick;
    if (rst) begin
      raw3q.delete(); s23q.delete(); raw2q.delete(); s22q.delete();
      m_deb3 = 1'b1; m_deb2 = 1'b1; m_running = 1'b1;
      m_kp = 1'b0; m_sp = 1'b0; m_tick = 1'b0; runcnt = 0;
    end else begin
      raw3q.push_back(k3);
      s23q.push_back(sync_out(raw3q));
      raw2q.push_back(k2);
      s22q.push_back(sync_out(raw2q));
      n_kp = 1'b0;
      if (win_flip(s23q, m_deb3)) begin
        n_kp   = m_deb3;
        m_deb3 = ~m_deb3;
      end
      n_sp = 1'b0;
      if (win_flip(s22q, m_deb2)) begin
        n_sp   = m_deb2;
        m_deb2 = ~m_deb2;
      end
      n_tick = m_running && ((runcnt % DIV) == DIV - 1);
`ifdef COUNT_TICK_STEP_EN
      n_tick = n_tick || (!m_running && m_sp);
`endif
      if (m_running) runcnt++;
      m_running = m_running ^ m_kp;
      m_kp   = n_kp;
      m_sp   = n_sp;
      m_tick = n_tick;
      while (raw3q.size() > 4) void'(raw3q.pop_front());
      while (raw2q.size() > 4) void'(raw2q.pop_front());
      while (s23q.size() > DEB + 2) void'(s23q.pop_front());
      while (s22q.size() > DEB + 2) void'(s22q.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    checks++;
    assert (tick === m_tick) else begin
      errors++;
      $error("FAIL tick: observed %b expected %b at %0t", tick, m_tick, $time);
    end
    checks++;
    assert (running === m_running) else begin
      errors++;
      $error("FAIL running: observed %b expected %b at %0t", running, m_running, $time);
    end
    checks++;
    assert (kp === m_kp) else begin
      errors++;
      $error("FAIL key_pressed: observed %b expected %b at %0t", kp, m_kp, $time);
    end
  endtask

  task automatic press3(input int n);
    k3 = 1'b0;
    repeat (n) cyc();
    k3 = 1'b1;
  endtask

  task automatic press2(input int n);
    k2 = 1'b0;
    repeat (n) cyc();
    k2 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; k3 = 1'b1; k2 = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    repeat (35) cyc();

    // Short glitch: no press, cadence unchanged.
    press3(3);
    repeat (20) cyc();

    // Pause/resume from every prescaler phase, including coincident wrap.
    for (int p = 0; p < DIV; p++) begin
      rst = 1'b1; cyc(); rst = 1'b0;
      repeat (p) cyc();
      press3(20);
      repeat (25) cyc();
      press3(20);
      repeat (25) cyc();
    end

    // Reset in the middle of a debounce and a partial period.
    repeat (5) cyc();
    k3 = 1'b0;
    repeat (4) cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; k3 = 1'b1;
    repeat (25) cyc();

`ifdef COUNT_TICK_STEP_EN
    press3(12);
    repeat (5) cyc();
    for (int i = 0; i < 3; i++) begin
      press2(8);
      repeat (8) cyc();
    end
    // Step and resume landing together.
    k2 = 1'b0; k3 = 1'b0;
    repeat (10) cyc();
    k2 = 1'b1; k3 = 1'b1;
    repeat (10) cyc();
    press2(8);
    repeat (20) cyc();
`endif

    // Randomized key activity with occasional resets.
    repeat (2000) begin
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 7) == 0) k3 = ~k3;
      if ($urandom_range(0, 7) == 0) k2 = ~k2;
      cyc();
    end
    rst = 1'b0;
    repeat (5) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
